// File: rtl/sensor_scan_ctrl.sv
// Four-channel sensor scan controller: drives the mux select, samples the
// synchronized mux output after a settle interval and debounces each channel.
module sensor_scan_ctrl #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] key_state,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic       scan_done
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_COUNT + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_COUNT - 1);
  localparam logic [DW-1:0] DEB_ONE     = DW'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;

  logic                   sync_meta_r;
  logic                   sync_r;
  logic [1:0]             state_r;
  logic [SW-1:0]          settle_cnt_r;
  logic [1:0]             sel_r;
  logic [3:0]             key_state_r;
  logic [3:0]             key_press_r;
  logic [3:0]             key_release_r;
  logic                   scan_done_r;
  logic [3:0][DW-1:0]     deb_cnt_r;

  logic [1:0]             state_s;
  logic [SW-1:0]          settle_cnt_s;
  logic [1:0]             sel_s;
  logic [3:0]             key_state_s;
  logic [3:0]             key_press_s;
  logic [3:0]             key_release_s;
  logic                   scan_done_s;
  logic [3:0][DW-1:0]     deb_cnt_s;

  // Two-flop synchronizer for the asynchronous mux output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= mux_out;
      sync_r      <= sync_meta_r;
    end
  end

  // Next-state, select advance and per-channel debounce decisions.
  always_comb begin
    state_s       = state_r;
    settle_cnt_s  = settle_cnt_r;
    sel_s         = sel_r;
    key_state_s   = key_state_r;
    key_press_s   = 4'b0000;
    key_release_s = 4'b0000;
    scan_done_s   = 1'b0;
    deb_cnt_s     = deb_cnt_r;
    case (state_r)
      IDLE: begin
        settle_cnt_s = '0;
        if (enable) begin
          state_s = SETTLE;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (!enable) begin
          state_s      = IDLE;
          settle_cnt_s = '0;
        end else if (settle_cnt_r == SETTLE_LAST) begin
          state_s      = SAMPLE;
          settle_cnt_s = '0;
        end else begin
          settle_cnt_s = settle_cnt_r + SETTLE_ONE;
        end
      end
      SAMPLE: begin
        settle_cnt_s = '0;
        sel_s        = sel_r + 2'd1;
        scan_done_s  = (sel_r == 2'd3);
        if (enable) begin
          state_s = SETTLE;
        end else begin
          state_s = IDLE;
        end
        // A matching sample restarts the run; only consecutive mismatches flip the key.
        if (sync_r == key_state_r[sel_r]) begin
          deb_cnt_s[sel_r] = '0;
        end else if (deb_cnt_r[sel_r] == DEB_LAST) begin
          deb_cnt_s[sel_r]   = '0;
          key_state_s[sel_r] = sync_r;
          if (sync_r) begin
            key_press_s[sel_r] = 1'b1;
          end else begin
            key_release_s[sel_r] = 1'b1;
          end
        end else begin
          deb_cnt_s[sel_r] = deb_cnt_r[sel_r] + DEB_ONE;
        end
      end
      default: begin
        state_s      = IDLE;
        settle_cnt_s = '0;
      end
    endcase
  end

  // Scan state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      settle_cnt_r  <= '0;
      sel_r         <= 2'd0;
      key_state_r   <= 4'b0000;
      key_press_r   <= 4'b0000;
      key_release_r <= 4'b0000;
      scan_done_r   <= 1'b0;
      deb_cnt_r     <= '0;
    end else begin
      state_r       <= state_s;
      settle_cnt_r  <= settle_cnt_s;
      sel_r         <= sel_s;
      key_state_r   <= key_state_s;
      key_press_r   <= key_press_s;
      key_release_r <= key_release_s;
      scan_done_r   <= scan_done_s;
      deb_cnt_r     <= deb_cnt_s;
    end
  end

  assign sel         = sel_r;
  assign key_state   = key_state_r;
  assign key_press   = key_press_r;
  assign key_release = key_release_r;
  assign scan_done   = scan_done_r;

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Self-checking bench for sensor_scan_ctrl (SETTLE_CYCLES=4, DEBOUNCE_COUNT=3)
// using a scoreboard of expected per-sample results.
module tb_sensor_scan_ctrl;

  localparam int SETTLE = 4;
  localparam int DEB    = 3;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       mux_out;
  logic [1:0] sel;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic       scan_done;

  sensor_scan_ctrl #(.SETTLE_CYCLES(SETTLE), .DEBOUNCE_COUNT(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mux_out(mux_out),
    .sel(sel), .key_state(key_state), .key_press(key_press),
    .key_release(key_release), .scan_done(scan_done)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] ks;
    logic [3:0] pr;
    logic [3:0] rl;
    logic       done;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  logic [3:0] held_ks = 4'b0000;
  logic [1:0] m_sel = 2'd0;
  logic [3:0] m_ks = 4'b0000;
  int         m_cnt[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: pop and compare a result when sel moves, else require quiet outputs.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (mon_en) begin
      checks++;
      if (sel !== prev_sel) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: sel=%0d with no result pending", sel);
        end else begin
          e = exp_q.pop_front();
          held_ks = e.ks;
          if ({sel, key_state, key_press, key_release, scan_done} !== e) begin
            errors++;
            $display("FAIL sample_result: got sel=%0d ks=%b pr=%b rl=%b done=%b, want sel=%0d ks=%b pr=%b rl=%b done=%b",
                     sel, key_state, key_press, key_release, scan_done, e.sel, e.ks, e.pr, e.rl, e.done);
          end
        end
      end else if ({key_state, key_press, key_release, scan_done} !== {held_ks, 4'b0000, 4'b0000, 1'b0}) begin
        errors++;
        $display("FAIL quiet_cycle: got ks=%b pr=%b rl=%b done=%b, want ks=%b and no pulses",
                 key_state, key_press, key_release, scan_done, held_ks);
      end
    end
    prev_sel = sel;
  endtask

  task automatic model_clear();
    m_sel = 2'd0;
    m_ks  = 4'b0000;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic push_expect(input logic v);
    exp_t e;
    e = '0;
    if (v == m_ks[m_sel]) begin
      m_cnt[m_sel] = 0;
    end else if (m_cnt[m_sel] + 1 == DEB) begin
      m_ks[m_sel]  = v;
      m_cnt[m_sel] = 0;
      if (v) e.pr[m_sel] = 1'b1;
      else   e.rl[m_sel] = 1'b1;
    end else begin
      m_cnt[m_sel] = m_cnt[m_sel] + 1;
    end
    e.done = (m_sel == 2'd3);
    m_sel  = m_sel + 2'd1;
    e.sel  = m_sel;
    e.ks   = m_ks;
    exp_q.push_back(e);
  endtask

  task automatic wait_result(input int exp_cyc);
    int n;
    logic [1:0] s0;
    s0 = sel;
    n  = 0;
    do begin
      tick();
      n++;
    end while (sel === s0 && n < 40);
    checks++;
    if (sel === s0) begin
      errors++;
      $display("FAIL sample_timeout: sel stuck at %0d after %0d cycles", sel, n);
    end else if (n != exp_cyc) begin
      errors++;
      $display("FAIL dwell_cycles: got %0d cycles, want %0d", n, exp_cyc);
    end
  endtask

  task automatic run_dwell(input logic v, input int exp_cyc);
    mux_out = v;
    push_expect(v);
    wait_result(exp_cyc);
  endtask

  task automatic run_scan(input logic [3:0] pattern, input int first_cyc);
    for (int c = 0; c < 4; c++) run_dwell(pattern[m_sel], (c == 0) ? first_cyc : SETTLE + 1);
  endtask

  task automatic check_ks(input logic [3:0] want, input string name);
    checks++;
    if (key_state !== want) begin
      errors++;
      $display("FAIL %s: key_state=%b, want %b", name, key_state, want);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({sel, key_state, key_press, key_release, scan_done} !== 15'd0) begin
      errors++;
      $display("FAIL %s: sel=%0d ks=%b pr=%b rl=%b done=%b, want all 0",
               name, sel, key_state, key_press, key_release, scan_done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    mux_out = 1'b0;
    model_clear();
    tick();
    tick();
    check_zero_outputs("reset_state");
    reset_n = 1'b1;
    enable  = 1'b1;
    held_ks = 4'b0000;
    mon_en  = 1'b1;
  endtask

  task automatic test_idle_scan();
    run_scan(4'b0000, SETTLE + 2);
    run_scan(4'b0000, SETTLE + 1);
    run_scan(4'b0000, SETTLE + 1);
    check_ks(4'b0000, "idle_scan_state");
  endtask

  task automatic test_press_ch2();
    for (int s = 0; s < 3; s++) run_scan(4'b0100, SETTLE + 1);
    check_ks(4'b0100, "press_ch2_state");
    for (int s = 0; s < 3; s++) run_scan(4'b0000, SETTLE + 1);
    check_ks(4'b0000, "release_ch2_state");
  endtask

  task automatic test_bounce_ch1();
    run_scan(4'b0010, SETTLE + 1);
    run_scan(4'b0010, SETTLE + 1);
    run_scan(4'b0000, SETTLE + 1);
    run_scan(4'b0010, SETTLE + 1);
    run_scan(4'b0010, SETTLE + 1);
    check_ks(4'b0000, "bounce_no_press");
    run_scan(4'b0010, SETTLE + 1);
    check_ks(4'b0010, "bounce_then_press");
  endtask

  task automatic test_enable_settle();
    run_dwell(1'b0, SETTLE + 1);
    mux_out = 1'b1;
    push_expect(1'b1);
    tick();
    tick();
    enable = 1'b0;
    tick();
    checks++;
    if (dut.state_r !== 2'd0 || sel !== 2'd1) begin
      errors++;
      $display("FAIL settle_abort: state=%0d sel=%0d, want state=0 sel=1", dut.state_r, sel);
    end
    check_ks(4'b0010, "settle_abort_state");
    repeat (3) tick();
    checks++;
    if (sel !== 2'd1) begin
      errors++;
      $display("FAIL settle_abort_hold: sel=%0d, want 1", sel);
    end
    enable = 1'b1;
    wait_result(SETTLE + 2);
  endtask

  task automatic test_enable_sample();
    run_dwell(1'b0, SETTLE + 1);
    mux_out = 1'b1;
    push_expect(1'b1);
    repeat (SETTLE) tick();
    checks++;
    if (dut.state_r !== 2'd2 || sel !== 2'd3) begin
      errors++;
      $display("FAIL sample_entry: state=%0d sel=%0d, want state=2 sel=3", dut.state_r, sel);
    end
    enable = 1'b0;
    wait_result(1);
    tick();
    checks++;
    if (dut.state_r !== 2'd0 || sel !== 2'd0) begin
      errors++;
      $display("FAIL sample_then_idle: state=%0d sel=%0d, want state=0 sel=0", dut.state_r, sel);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    run_scan(4'b1010, SETTLE + 2);
    run_scan(4'b1010, SETTLE + 1);
    check_ks(4'b1010, "pre_reset_state");
    run_scan(4'b1011, SETTLE + 1);
    run_scan(4'b1011, SETTLE + 1);
    mux_out = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    mon_en = 1'b0;
    exp_q.delete();
    model_clear();
    tick();
    tick();
    check_zero_outputs("reset_held");
    reset_n = 1'b1;
    held_ks = 4'b0000;
    mon_en  = 1'b1;
    run_scan(4'b0001, SETTLE + 2);
    run_scan(4'b0001, SETTLE + 1);
    check_ks(4'b0000, "counters_cleared");
    run_scan(4'b0001, SETTLE + 1);
    check_ks(4'b0001, "post_reset_press");
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_press_ch2();
    test_bounce_ch1();
    test_enable_settle();
    test_enable_sample();
    test_reset_mid();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
